lamp_ramp_sequencer: RTL and testbench

//  Sequences the room lamp bank toward the lamp count implied by time code,

---
 rtl/lamp_ramp_sequencer.sv | 82 ++++++++
 tb/tb_lamp_ramp_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_ramp_sequencer.sv
// lamp_ramp_sequencer: steps the lamp bank one lamp at a time toward a decoded target count.
// Build option TARGET_CLAMP_EN: clamp over-range targets to MAX_LAMPS instead of rejecting them.
module lamp_ramp_sequencer #(
   parameter int MAX_LAMPS   = 15,
   parameter int STEP_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [3:0]           tcode,
   input  logic [3:0]           ulight,
   input  logic [3:0]           lenght,
   output logic [3:0]           target,
   output logic [3:0]           active_count,
   output logic [MAX_LAMPS-1:0] lamp_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);
   localparam int pw = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
   localparam logic [pw-1:0] last_pre = pw'(STEP_CYCLES - 1);
   localparam logic [3:0] max_cnt = 4'(MAX_LAMPS);
   localparam logic [1:0] s_idle = 2'd0, s_up = 2'd1, s_down = 2'd2;
   logic [1:0]    state;
   logic [pw-1:0] pre;
   logic [3:0]    dec, inc, dn;
   logic          legal, over, can_up, can_dn, done_q, is_up;
   assign dec    = tcode == 4'b1000 ? ulight : tcode == 4'b0100 ? lenght >> 2 : 4'd0;
   assign legal  = tcode inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
   assign over   = dec > max_cnt;
   assign inc    = active_count + 4'd1;
   assign dn     = active_count - 4'd1;
   assign can_up = target > active_count && active_count < max_cnt;
   assign can_dn = target < active_count;
   assign is_up  = state == s_up;
   assign busy   = active_count != target;
   assign done   = done_q & en;
   for (genvar i = 0; i < MAX_LAMPS; i++) begin : g_mask
      assign lamp_mask[i] = active_count > 4'(i);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         target       <= '0;
         active_count <= '0;
         pre          <= '0;
         state        <= s_idle;
         done_q       <= 1'b0;
         cfg_err      <= 1'b0;
      end else if (!en) begin
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!legal) cfg_err <= 1'b1;
`ifdef TARGET_CLAMP_EN
         else target <= over ? max_cnt : dec;
`else
         else if (over) cfg_err <= 1'b1;
         else target <= dec;
`endif
         if (state == s_idle) begin
            pre   <= '0;
            state <= can_up ? s_up : can_dn ? s_down : s_idle;
         end else if (pre != last_pre) begin
            pre <= pre + 1'b1;
         end else begin
            pre <= '0;
            // a reversal only turns around here; the next step comes a full period later
            if (is_up ? can_up : can_dn) begin
               active_count <= is_up ? inc : dn;
               if ((is_up ? inc : dn) == target) begin
                  state  <= s_idle;
                  done_q <= 1'b1;
               end
            end else if (is_up ? can_dn : can_up) begin
               state <= is_up ? s_down : s_up;
            end else begin
               state  <= s_idle;
               done_q <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_lamp_ramp_sequencer.sv
// tb_lamp_ramp_sequencer: directed checks of ramping, reversal, config errors, freeze and reset.
module tb_lamp_ramp_sequencer;
   logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic [3:0] tcode = '0, ulight = '0, lenght = '0;
   logic [3:0] target, active_count, t8, c8;
   logic [14:0] lamp_mask;
   logic [7:0] m8;
   logic busy, done, cfg_err, b8, d8, e8;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   lamp_ramp_sequencer dut (
      .clk(clk), .rst_n(rst_n), .en(en), .tcode(tcode), .ulight(ulight), .lenght(lenght),
      .target(target), .active_count(active_count), .lamp_mask(lamp_mask),
      .busy(busy), .done(done), .cfg_err(cfg_err));
   lamp_ramp_sequencer #(.MAX_LAMPS(8), .STEP_CYCLES(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .tcode(tcode), .ulight(ulight), .lenght(lenght),
      .target(t8), .active_count(c8), .lamp_mask(m8),
      .busy(b8), .done(d8), .cfg_err(e8));
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk_count(input string name, input logic [3:0] exp_c, input logic exp_d);
      tests++;
      if (active_count !== exp_c || done !== exp_d) begin
         fails++;
         $display("FAIL %s: count=%0d done=%b, expected count=%0d done=%b", name, active_count, done, exp_c, exp_d);
      end
   endtask
   task automatic do_reset;
      rst_n = 1'b0;
      tcode = 4'b0000;
      step(1);
      rst_n = 1'b1;
   endtask
   task automatic test_reset;
      en = 1'b1; tcode = 4'b1000; ulight = 4'd3; lenght = 4'd0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({target, active_count, lamp_mask, busy, done, cfg_err, t8, c8, m8, d8, e8} !== '0) begin
         fails++;
         $display("FAIL reset_async: t=%0d c=%0d m=%h b=%b d=%b e=%b t8=%0d m8=%h, expected all 0",
                  target, active_count, lamp_mask, busy, done, cfg_err, t8, m8);
      end
      step(2);
      tests++;
      if ({target, active_count, lamp_mask, busy, done, cfg_err} !== '0) begin
         fails++;
         $display("FAIL reset_hold: t=%0d c=%0d m=%h b=%b d=%b e=%b, expected all 0",
                  target, active_count, lamp_mask, busy, done, cfg_err);
      end
      rst_n = 1'b1;
   endtask
   task automatic test_ramp_up;
      step(1);
      tests++;
      if (target !== 4'd3 || busy !== 1'b1) begin
         fails++;
         $display("FAIL up_target: target=%0d busy=%b, expected 3 1", target, busy);
      end
      step(4); chk_count("up_before_first", 4'd0, 1'b0);
      step(1); chk_count("up_first", 4'd1, 1'b0);
      step(4); chk_count("up_second", 4'd2, 1'b0);
      step(3); chk_count("up_pre_third", 4'd2, 1'b0);
      step(1); chk_count("up_third", 4'd3, 1'b1);
      tests++;
      if (lamp_mask !== 15'h0007 || busy !== 1'b0) begin
         fails++;
         $display("FAIL up_mask: mask=%h busy=%b, expected 0007 0", lamp_mask, busy);
      end
      step(1); chk_count("up_done_drop", 4'd3, 1'b0);
   endtask
   task automatic test_ramp_down;
      tcode = 4'b0000;
      step(1);
      tests++;
      if (target !== 4'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL down_target: target=%0d busy=%b, expected 0 1", target, busy);
      end
      step(4); chk_count("down_hold", 4'd3, 1'b0);
      step(1); chk_count("down_first", 4'd2, 1'b0);
      step(4); chk_count("down_second", 4'd1, 1'b0);
      step(4); chk_count("down_third", 4'd0, 1'b1);
      tests++;
      if (lamp_mask !== 15'h0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL down_mask: mask=%h busy=%b, expected 0000 0", lamp_mask, busy);
      end
      step(1); chk_count("down_no_wrap", 4'd0, 1'b0);
   endtask
   task automatic test_reverse;
      tcode = 4'b1000; ulight = 4'd6;
      step(1);
      step(9); chk_count("rev_at_two", 4'd2, 1'b0);
      ulight = 4'd1;
      step(1);
      tests++;
      if (target !== 4'd1) begin
         fails++;
         $display("FAIL rev_target: target=%0d, expected 1", target);
      end
      step(3); chk_count("rev_boundary_no_overshoot", 4'd2, 1'b0);
      step(3); chk_count("rev_restart_prescaler", 4'd2, 1'b0);
      step(1); chk_count("rev_down_done", 4'd1, 1'b1);
      step(1); chk_count("rev_done_drop", 4'd1, 1'b0);
   endtask
   task automatic test_clamp;
      do_reset;
      tcode = 4'b1000; ulight = 4'd8;
      step(1);
      tests++;
      if (t8 !== 4'd8 || e8 !== 1'b0) begin
         fails++;
         $display("FAIL clamp_at_max: t8=%0d e8=%b, expected 8 0", t8, e8);
      end
      ulight = 4'd5;
      step(1);
      tests++;
      if (t8 !== 4'd5) begin
         fails++;
         $display("FAIL clamp_in_range: t8=%0d, expected 5", t8);
      end
      ulight = 4'd12;
      step(1);
      tests++;
      if (target !== 4'd12 || cfg_err !== 1'b0) begin
         fails++;
         $display("FAIL clamp_wide_dut: target=%0d cfg_err=%b, expected 12 0", target, cfg_err);
      end
`ifdef TARGET_CLAMP_EN
      tests++;
      if (t8 !== 4'd8 || e8 !== 1'b0) begin
         fails++;
         $display("FAIL clamp_over: t8=%0d e8=%b, expected 8 0", t8, e8);
      end
      step(40);
      tests++;
      if (m8 !== 8'hFF || c8 !== 4'd8) begin
         fails++;
         $display("FAIL clamp_mask: m8=%h c8=%0d, expected FF 8", m8, c8);
      end
`else
      tests++;
      if (t8 !== 4'd5 || e8 !== 1'b1) begin
         fails++;
         $display("FAIL reject_over: t8=%0d e8=%b, expected 5 1", t8, e8);
      end
      step(40);
      tests++;
      if (m8 !== 8'h1F || c8 !== 4'd5) begin
         fails++;
         $display("FAIL reject_mask: m8=%h c8=%0d, expected 1F 5", m8, c8);
      end
`endif
   endtask
   task automatic test_cfg_err;
      tcode = 4'b0100; lenght = 4'd13;
      step(1);
      tests++;
      if (target !== 4'd3 || cfg_err !== 1'b0) begin
         fails++;
         $display("FAIL len_decode: target=%0d cfg_err=%b, expected 3 0", target, cfg_err);
      end
      tcode = 4'b0011;
      step(1);
      tests++;
      if (target !== 4'd3 || cfg_err !== 1'b1 || e8 !== 1'b1) begin
         fails++;
         $display("FAIL bad_tcode: target=%0d cfg_err=%b e8=%b, expected 3 1 1", target, cfg_err, e8);
      end
      tcode = 4'b1000; ulight = 4'd7;
      step(1);
      tests++;
      if (target !== 4'd7 || cfg_err !== 1'b1) begin
         fails++;
         $display("FAIL cfg_sticky: target=%0d cfg_err=%b, expected 7 1", target, cfg_err);
      end
      tcode = 4'b0010;
      step(1);
      tests++;
      if (target !== 4'd0 || cfg_err !== 1'b1) begin
         fails++;
         $display("FAIL tcode_0010: target=%0d cfg_err=%b, expected 0 1", target, cfg_err);
      end
   endtask
   task automatic test_en_freeze;
      do_reset;
      tcode = 4'b1000; ulight = 4'd4;
      step(11); chk_count("frz_before", 4'd2, 1'b0);
      en = 1'b0; ulight = 4'd9;
      step(10); chk_count("frz_count", 4'd2, 1'b0);
      tests++;
      if (target !== 4'd4 || busy !== 1'b1) begin
         fails++;
         $display("FAIL frz_target: target=%0d busy=%b, expected 4 1", target, busy);
      end
      ulight = 4'd4; en = 1'b1;
      step(2); chk_count("frz_prescaler_held", 4'd2, 1'b0);
      step(1); chk_count("frz_resume_step", 4'd3, 1'b0);
      step(4); chk_count("frz_resume_done", 4'd4, 1'b1);
      en = 1'b0;
      #1 chk_count("frz_done_forced", 4'd4, 1'b0);
      step(1);
      en = 1'b1;
      step(1); chk_count("frz_no_stale_done", 4'd4, 1'b0);
   endtask
   task automatic test_reset_mid;
      ulight = 4'd9;
      step(12);
      tests++;
      if (busy !== 1'b1 || active_count < 4'd5) begin
         fails++;
         $display("FAIL mid_ramping: busy=%b count=%0d, expected 1 and >=5", busy, active_count);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({target, active_count, lamp_mask, busy, done, cfg_err} !== '0) begin
         fails++;
         $display("FAIL mid_reset_async: t=%0d c=%0d m=%h b=%b d=%b e=%b, expected all 0",
                  target, active_count, lamp_mask, busy, done, cfg_err);
      end
      step(3);
      tests++;
      if ({target, active_count, done, c8, d8} !== '0) begin
         fails++;
         $display("FAIL mid_reset_hold: t=%0d c=%0d d=%b c8=%0d d8=%b, expected all 0",
                  target, active_count, done, c8, d8);
      end
      rst_n = 1'b1;
   endtask
   initial begin
      test_reset;
      test_ramp_up;
      test_ramp_down;
      test_reverse;
      test_clamp;
      test_cfg_err;
      test_en_freeze;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
